// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes: captures a 128-bit state, substitutes LANES bytes
// per clock through shared S-boxes, then holds the result on a valid/ready port.
// Byte i is bits [8*i+7:8*i] (column-major), the same map ShiftRows uses.
// Optional build macro: SUBBYTES_INV_EN adds the 'inv' port and the inverse S-box.
module subbytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
`ifdef SUBBYTES_INV_EN
  input  logic         inv,
`endif
  output logic         busy
);

  localparam int unsigned NSTEP = 16 / LANES;
  localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  // Reject lane counts that do not divide the state evenly into a power-of-two step count
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  buf_q, buf_d;

  // FIPS-197 forward S-box
  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

`ifdef SUBBYTES_INV_EN
  logic inv_q;

  // FIPS-197 inverse S-box
  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
    endcase
    return s;
  endfunction

  // Direction flag captured with the state and held for the whole operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else if (state_q == IDLE && in_valid) inv_q <= inv;
  end
`endif

  // Selected substitution for one byte
  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic use_inv);
`ifdef SUBBYTES_INV_EN
    return use_inv ? sbox_inv(b) : sbox_fwd(b);
`else
    return use_inv ? 8'h00 : sbox_fwd(b);
`endif
  endfunction

  logic sel_inv;
`ifdef SUBBYTES_INV_EN
  assign sel_inv = inv_q;
`else
  assign sel_inv = 1'b0;
`endif

  // State, step counter and working buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state: accept in IDLE, LANES bytes per clock in PROC, hand off in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_state;
          cnt_d   = '0;
          state_d = PROC;
        end
      end
      PROC: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          buf_d[8*(32'(cnt_q)*LANES + l) +: 8] = sub_byte(buf_q[8*(32'(cnt_q)*LANES + l) +: 8], sel_inv);
        end
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake outputs, derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_state <= '0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      if (state_q == PROC && state_d == DONE) out_state <= buf_d;
    end
  end

endmodule

// File: tb/tb_subbytes_iter.sv
// Directed bench for subbytes_iter at LANES = 4, 1 and 16 sharing one stimulus.
// Inverse-table vectors are included when SUBBYTES_INV_EN is defined.
module tb_subbytes_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         out_ready;
  logic         ir [3];
  logic         ov [3];
  logic         bz [3];
  logic [127:0] os [3];
`ifdef SUBBYTES_INV_EN
  logic         inv;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_lat [3] = '{4, 16, 1};
  int exp_per [3] = '{6, 18, 3};

  subbytes_iter #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_state(in_state),
    .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]),
`ifdef SUBBYTES_INV_EN
    .inv(inv),
`endif
    .busy(bz[0]));

  subbytes_iter #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state),
    .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]),
`ifdef SUBBYTES_INV_EN
    .inv(inv),
`endif
    .busy(bz[1]));

  subbytes_iter #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_state(in_state),
    .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]),
`ifdef SUBBYTES_INV_EN
    .inv(inv),
`endif
    .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one state, wait for all three instances and check latency and data
  task automatic accept_wait(input string tag, input logic [127:0] vin, input logic [127:0] vexp);
    int lat [3];
    lat = '{0, 0, 0};
    out_ready = 1'b0;
    in_state  = vin;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    in_state  = ~vin;
    check({tag, "_busy"}, 128'(bz[0]), 128'd1);
    check({tag, "_inrdy_lo"}, 128'(ir[0]), 128'd0);
    for (int c = 1; c <= 20; c++) begin
      step();
      for (int d = 0; d < 3; d++) if (ov[d] && lat[d] == 0) lat[d] = c;
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_lat%0d", tag, d), 128'(lat[d]), 128'(exp_lat[d]));
      check($sformatf("%s_data%0d", tag, d), os[d], vexp);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_idle_rdy%0d", tag, d), 128'(ir[d]), 128'd1);
      check($sformatf("%s_idle_ov%0d", tag, d), 128'(ov[d]), 128'd0);
    end
  endtask

  task automatic run_vec(input string tag, input logic [127:0] vin, input logic [127:0] vexp);
    accept_wait(tag, vin, vexp);
    release_out(tag);
  endtask

  localparam logic [127:0] APPB_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] APPB_OUT = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;

  initial begin
    int  pulses;
    int  rise [3][2];
    int  nrise [3];
    logic prev [3];
    logic seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
`ifdef SUBBYTES_INV_EN
    inv       = 1'b0;
`endif
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ov%0d", d), 128'(ov[d]), 128'd0);
      check($sformatf("rst_os%0d", d), os[d], 128'd0);
      check($sformatf("rst_ir%0d", d), 128'(ir[d]), 128'd1);
      check($sformatf("rst_bz%0d", d), 128'(bz[d]), 128'd0);
    end
    rst_n = 1'b1;
    step();

    // Substitution vectors
    run_vec("zero", 128'h0, {16{8'h63}});
    run_vec("appb", APPB_IN, APPB_OUT);
    run_vec("seq0", 128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'h76abd7fe_2b670130_c56f6bf2_7b777c63);
    run_vec("seqf", 128'hfffefdfc_fbfaf9f8_f7f6f5f4_f3f2f1f0, 128'h16bb54b0_0f2d9941_6842e6bf_0d89a18c);

    // Backpressure hold with ignored input pulses
    accept_wait("bp", APPB_IN, APPB_OUT);
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      in_state = {$urandom, $urandom, $urandom, $urandom};
      step();
      check("bp_ov", 128'(ov[0]), 128'd1);
      check("bp_os", os[0], APPB_OUT);
      check("bp_ir", 128'(ir[0]), 128'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    check("bp_busy", 128'(bz[0]), 128'd0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bz[0]) pulses++;
    end
    check("bp_no_accept", 128'(pulses), 128'd0);

    // Reset during PROC (and DONE for the single-step instance)
    in_state = APPB_IN;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("mid_ov%0d", d), 128'(ov[d]), 128'd0);
      check($sformatf("mid_os%0d", d), os[d], 128'd0);
      check($sformatf("mid_ir%0d", d), 128'(ir[d]), 128'd1);
      check($sformatf("mid_bz%0d", d), 128'(bz[d]), 128'd0);
    end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      step();
      for (int d = 0; d < 3; d++) if (ov[d] || bz[d]) seen = 1'b1;
    end
    check("mid_no_output", 128'(seen), 128'd0);
    run_vec("post_rst", APPB_IN, APPB_OUT);

    // Throughput with out_ready and in_valid held high
    nrise = '{0, 0, 0};
    prev  = '{1'b0, 1'b0, 1'b0};
    rise  = '{'{0, 0}, '{0, 0}, '{0, 0}};
    in_state  = 128'h0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && !prev[d] && nrise[d] < 2) begin
          rise[d][nrise[d]] = c;
          nrise[d]++;
        end
        prev[d] = ov[d];
      end
    end
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("tput_n%0d", d), 128'(nrise[d]), 128'd2);
      check($sformatf("tput_per%0d", d), 128'(rise[d][1] - rise[d][0]), 128'(exp_per[d]));
    end
    for (int c = 0; c < 40; c++) step();
    out_ready = 1'b0;

`ifdef SUBBYTES_INV_EN
    // Inverse table vectors, then back to forward
    inv = 1'b1;
    run_vec("inv63", {16{8'h63}}, 128'h0);
    run_vec("inv16", {16{8'h16}}, {16{8'hff}});
    run_vec("invappb", APPB_OUT, APPB_IN);
    inv = 1'b0;
    run_vec("fwd_again", APPB_IN, APPB_OUT);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
